// File: rtl/jtpopeye_objdma.sv
// jtpopeye_objdma
// ---------------
// Object-RAM DMA for the Popeye video path. Once the CPU has armed a transfer
// (dma_req high on a vertical-blank rising edge), the block requests the CPU
// bus and copies NBYTES bytes from CPU work RAM, starting at SRC_BASE, into
// object RAM. It moves one byte per two pixel-clock enables, and only while
// the timing generator's DMA window (HBD_n low) is open. If blanking ends
// before the copy finishes, the transfer is abandoned and overrun is flagged.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   pxl_cen         pixel clock enable (clk/4)
//   VB              vertical blank, high = blank
//   HBD_n           DMA window, low = byte moves allowed
//   dma_req         CPU arm request (level)
//   busak           CPU bus acknowledge
//   src_din         CPU RAM read data (one clk after src_addr)
//   busrq           CPU bus request
//   src_addr        CPU RAM read address
//   obj_addr/dout   object RAM write address/data
//   obj_we          object RAM write strobe (one clk)
//   busy            transfer in progress (ARMED..RELEASE)
//   done            one-clk pulse on successful completion
//   overrun         sticky: blank ended before completion
module jtpopeye_objdma #(
    parameter int             NBYTES   = 128,
    parameter int             SAW      = 10,
    parameter logic [SAW-1:0] SRC_BASE = 10'h200,
    parameter int             OAW      = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pxl_cen,
    input  logic           VB,
    input  logic           HBD_n,
    input  logic           dma_req,
    input  logic           busak,
    input  logic [7:0]     src_din,
    output logic           busrq,
    output logic [SAW-1:0] src_addr,
    output logic [OAW-1:0] obj_addr,
    output logic [7:0]     obj_dout,
    output logic           obj_we,
    output logic           busy,
    output logic           done,
    output logic           overrun
);

    localparam int            CW   = OAW + 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        REQ     = 3'd2,
        ADDR    = 3'd3,
        WRITE   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          vb_r;
    logic          vb_rise_s, vb_fall_s;
    logic          write_s;
    logic          overrun_set_s;

    logic           busrq_r, obj_we_r, busy_r, done_r, overrun_r;
    logic [SAW-1:0] src_addr_r;
    logic [OAW-1:0] obj_addr_r;
    logic [7:0]     obj_dout_r;

    assign vb_rise_s = VB & ~vb_r;
    assign vb_fall_s = ~VB & vb_r;

    // Next-state, byte counter and write-strobe decode
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        write_s       = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (vb_rise_s && dma_req) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARMED: begin
                cnt_nxt_s = {CW{1'b0}};
                if (vb_fall_s) begin
                    overrun_set_s = 1'b1;
                    state_nxt_s   = RELEASE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            REQ: begin
                if (vb_fall_s) begin
                    overrun_set_s = 1'b1;
                    state_nxt_s   = RELEASE;
                end else if (busak) begin
                    state_nxt_s = ADDR;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            ADDR: begin
                // busak low freezes here; HBD_n high simply waits
                if (vb_fall_s) begin
                    overrun_set_s = 1'b1;
                    state_nxt_s   = RELEASE;
                end else if (pxl_cen && !HBD_n && busak) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            WRITE: begin
                // completes regardless of HBD_n, but not while the bus is stolen
                if (vb_fall_s) begin
                    overrun_set_s = 1'b1;
                    state_nxt_s   = RELEASE;
                end else if (pxl_cen && busak) begin
                    write_s   = 1'b1;
                    cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST) begin
                        state_nxt_s = RELEASE;
                    end else begin
                        state_nxt_s = ADDR;
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            RELEASE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            vb_r       <= 1'b1;   // no spurious VB rise straight out of reset
            busrq_r    <= 1'b0;
            obj_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
            src_addr_r <= SRC_BASE;
            obj_addr_r <= {OAW{1'b0}};
            obj_dout_r <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            vb_r       <= VB;
            busy_r     <= (state_nxt_s != IDLE);
            // done only when RELEASE was reached without an overrun
            done_r     <= (state_r == RELEASE) && !overrun_r;
            obj_we_r   <= write_s;
            src_addr_r <= SRC_BASE + SAW'(cnt_nxt_s);
            // request rises entering REQ, falls as RELEASE is left
            if (state_nxt_s == REQ) begin
                busrq_r <= 1'b1;
            end else if (state_r == RELEASE) begin
                busrq_r <= 1'b0;
            end else begin
                busrq_r <= busrq_r;
            end
            if (state_nxt_s == ARMED) begin
                overrun_r <= 1'b0;
            end else if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            if (write_s) begin
                obj_addr_r <= cnt_r[OAW-1:0];
                obj_dout_r <= src_din;
            end else begin
                obj_addr_r <= obj_addr_r;
                obj_dout_r <= obj_dout_r;
            end
        end
    end

    assign busrq    = busrq_r;
    assign src_addr = src_addr_r;
    assign obj_addr = obj_addr_r;
    assign obj_dout = obj_dout_r;
    assign obj_we   = obj_we_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_jtpopeye_objdma.sv
module tb_jtpopeye_objdma;

    logic       clk = 1'b0;
    logic       rst, VB, dma_req, HBD_n, pxl_cen;
    logic       busak = 1'b0;
    logic [7:0] src_din = 8'h00;
    logic       busrq, obj_we, busy, done, overrun;
    logic [9:0] src_addr;
    logic [6:0] obj_addr;
    logic [7:0] obj_dout;

    logic       steal = 1'b0;
    logic       hbd_mode = 1'b0;
    logic       busrq_d1 = 1'b0;
    logic [1:0] pxl_cnt = 2'd0;
    int         hcnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    // per-run monitor state, cleared when busy rises
    logic [7:0] mem [0:127];
    int   run_we = 0, seq_err = 0, done_cnt = 0, done_bad = 0;
    int   late = 0, win_wr = 0, max_win = 0;
    logic busy_q = 1'b0, we_q = 1'b0;

    jtpopeye_objdma dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(VB), .HBD_n(HBD_n),
        .dma_req(dma_req), .busak(busak), .src_din(src_din), .busrq(busrq),
        .src_addr(src_addr), .obj_addr(obj_addr), .obj_dout(obj_dout),
        .obj_we(obj_we), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    assign pxl_cen = (pxl_cnt == 2'd3);
    assign HBD_n   = hbd_mode ? (hcnt >= 16) : 1'b0;

    // pixel enable, line position, CPU RAM and bus-ack models
    always @(posedge clk) begin
        pxl_cnt  <= pxl_cnt + 2'd1;
        if (pxl_cen) hcnt <= (hcnt == 319) ? 0 : hcnt + 1;
        src_din  <= src_addr[7:0];
        busrq_d1 <= busrq;
        busak    <= busrq_d1 & ~steal;
    end

    // write / done monitor
    always @(negedge clk) begin
        busy_q <= busy;
        we_q   <= obj_we;
        if (busy && !busy_q) begin
            run_we <= 0; seq_err <= 0; done_cnt <= 0; done_bad <= 0;
            late <= 0; win_wr <= 0; max_win <= 0;
            for (int i = 0; i < 128; i++) mem[i] <= 8'hFF;
        end else begin
            if (obj_we) begin
                mem[obj_addr] <= obj_dout;
                if (obj_addr !== run_we[6:0]) seq_err <= seq_err + 1;
                run_we <= run_we + 1;
                if (hbd_mode) begin
                    if (hcnt == 0 || hcnt > 17) late <= late + 1;
                    else begin
                        win_wr <= win_wr + 1;
                        if (win_wr + 1 > max_win) max_win <= win_wr + 1;
                    end
                end
            end else if (hcnt == 18) begin
                win_wr <= 0;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (!we_q || busrq) done_bad <= done_bad + 1;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic arm();
        VB = 1'b0; dma_req = 1'b1;
        tick(3);
        VB = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy && n < budget) begin tick(1); n++; end
        ok = !busy;
    endtask

    task automatic wait_we(input int target, input int budget, output bit ok);
        int n = 0;
        while (run_we < target && n < budget) begin tick(1); n++; end
        ok = (run_we >= target);
    endtask

    task automatic test_reset();
        rst = 1'b1; VB = 1'b0; dma_req = 1'b0;
        tick(4);
        n_tests++; if (busrq !== 1'b0)     begin n_fail++; $display("FAIL reset_busrq got %b want 0", busrq); end
        n_tests++; if (obj_we !== 1'b0)    begin n_fail++; $display("FAIL reset_obj_we got %b want 0", obj_we); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_tests++; if (src_addr !== 10'h200) begin n_fail++; $display("FAIL reset_src_addr got %h want 200", src_addr); end
        n_tests++; if (obj_addr !== 7'h00) begin n_fail++; $display("FAIL reset_obj_addr got %h want 00", obj_addr); end
        n_tests++; if (obj_dout !== 8'h00) begin n_fail++; $display("FAIL reset_obj_dout got %h want 00", obj_dout); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic check_full_run(input string tag);
        int bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== i[7:0]) bad++;
        n_tests++; if (run_we !== 128) begin n_fail++; $display("FAIL %s_we_count got %0d want 128", tag, run_we); end
        n_tests++; if (seq_err !== 0)  begin n_fail++; $display("FAIL %s_addr_seq got %0d errors want 0", tag, seq_err); end
        n_tests++; if (bad !== 0)      begin n_fail++; $display("FAIL %s_contents got %0d bad bytes want 0", tag, bad); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done_count got %0d want 1", tag, done_cnt); end
        n_tests++; if (done_bad !== 0) begin n_fail++; $display("FAIL %s_done_timing got %0d bad want 0", tag, done_bad); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL %s_overrun got %b want 0", tag, overrun); end
    endtask

    task automatic test_basic();
        bit ok;
        arm();
        tick(1);
        n_tests++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL basic_busy_armed got %b want 1", busy); end
        n_tests++; if (busrq !== 1'b0) begin n_fail++; $display("FAIL basic_busrq_1clk got %b want 0", busrq); end
        tick(1);
        n_tests++; if (busrq !== 1'b1) begin n_fail++; $display("FAIL basic_busrq_2clk got %b want 1", busrq); end
        wait_idle(3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got busy=%b want 0", busy); end
        tick(2);
        check_full_run("basic");
        n_tests++; if (busrq !== 1'b0) begin n_fail++; $display("FAIL basic_busrq_end got %b want 0", busrq); end
    endtask

    task automatic test_window();
        bit ok;
        hbd_mode = 1'b1;
        arm();
        tick(2);
        wait_idle(30000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL window_timeout got busy=%b want 0", busy); end
        tick(2);
        check_full_run("window");
        n_tests++; if (late !== 0)   begin n_fail++; $display("FAIL window_closed_writes got %0d want 0", late); end
        n_tests++; if (max_win > 8)  begin n_fail++; $display("FAIL window_max_bytes got %0d want <=8", max_win); end
        hbd_mode = 1'b0;
    endtask

    task automatic test_bus_steal();
        bit ok;
        int w0, w1;
        logic rq_mid;
        arm();
        tick(2);
        wait_we(41, 3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL steal_reach41 got %0d want 41", run_we); end
        steal = 1'b1;
        tick(1);
        w0 = run_we;
        tick(24);
        rq_mid = busrq;
        tick(24);
        w1 = run_we;
        steal = 1'b0;
        n_tests++; if (w1 - w0 !== 0) begin n_fail++; $display("FAIL steal_gap_writes got %0d want 0", w1 - w0); end
        n_tests++; if (rq_mid !== 1'b1) begin n_fail++; $display("FAIL steal_busrq_held got %b want 1", rq_mid); end
        wait_idle(3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL steal_timeout got busy=%b want 0", busy); end
        tick(2);
        check_full_run("steal");
    endtask

    task automatic test_overrun();
        bit ok;
        arm();
        tick(2);
        wait_we(60, 3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovr_reach60 got %0d want 60", run_we); end
        VB = 1'b0;
        tick(1);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun); end
        tick(1);
        n_tests++; if (busrq !== 1'b0)   begin n_fail++; $display("FAIL ovr_busrq got %b want 0", busrq); end
        tick(4);
        n_tests++; if (run_we !== 60)    begin n_fail++; $display("FAIL ovr_bytes got %0d want 60", run_we); end
        n_tests++; if (done_cnt !== 0)   begin n_fail++; $display("FAIL ovr_done got %0d want 0", done_cnt); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL ovr_busy got %b want 0", busy); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        arm();
        tick(1);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear_on_arm got %b want 0", overrun); end
        wait_idle(3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovr_rearm_timeout got busy=%b want 0", busy); end
        tick(2);
        check_full_run("rearm");
    endtask

    task automatic test_not_armed();
        bit ok;
        int hi = 0;
        VB = 1'b0; dma_req = 1'b0;
        tick(3);
        VB = 1'b1;
        tick(4);
        dma_req = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(1); if (busrq) hi++; end
        n_tests++; if (hi !== 0)      begin n_fail++; $display("FAIL notarm_busrq got %0d high clk want 0", hi); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL notarm_busy got %b want 0", busy); end
        arm();
        tick(2);
        wait_idle(3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL notarm_timeout got busy=%b want 0", busy); end
        tick(2);
        check_full_run("notarm");
    endtask

    task automatic test_reset_mid();
        bit ok;
        arm();
        tick(2);
        wait_we(20, 3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach20 got %0d want 20", run_we); end
        rst = 1'b1;
        tick(1);
        n_tests++; if (busrq !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busrq got %b want 0", busrq); end
        n_tests++; if (obj_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_obj_we got %b want 0", obj_we); end
        n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        rst = 1'b0;
        tick(5);
        n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_no_rearm got %b want 0", busy); end
        arm();
        tick(2);
        wait_idle(3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout got busy=%b want 0", busy); end
        tick(2);
        check_full_run("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_bus_steal();
        test_overrun();
        test_not_armed();
        test_reset_mid();
        VB = 1'b0;
        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtpopeye_objdma.md
# jtpopeye_objdma

Object-RAM DMA controller for the Popeye video path, sitting directly downstream of the video timing generator. On the first vertical blank after the CPU arms a transfer, it requests the CPU bus, then copies a fixed block of CPU work RAM into the object (sprite) RAM. Each byte is moved only while the timing generator's DMA window (HBD_n low) is open. It produces the sprite list the object engine reads during the next active frame.

## Interface
Parameters:
- NBYTES, 128: bytes copied per transfer; power of two, 2–256.
- SAW, 10: CPU source address width.
- SRC_BASE, 10'h200: first CPU source address.
- OAW, 7: object RAM address width; log2(NBYTES).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- pxl_cen  in  1  pixel clock enable (clk/4) from timing block.
- VB  in  1  vertical blank from timing block, high = blank.
- HBD_n  in  1  DMA window from timing block; low = byte moves allowed.
- dma_req  in  1  CPU arm request (DM10 latch), level.
- busak  in  1  CPU bus acknowledge, active-high.
- src_din  in  8  CPU RAM read data, valid one clk after src_addr changes.
- busrq  out  1  CPU bus request, active-high.
- src_addr  out  SAW  CPU RAM read address.
- obj_addr  out  OAW  object RAM write address.
- obj_dout  out  8  object RAM write data.
- obj_we  out  1  object RAM write strobe, one clk wide.
- busy  out  1  high from ARMED through RELEASE.
- done  out  1  one-clk pulse on successful completion.
- overrun  out  1  sticky; set when VB falls before completion, cleared when the next transfer is armed.

## Operation
- States: IDLE, ARMED, REQ, ADDR, WRITE, RELEASE.
- IDLE: on the clk where VB rises (VB high, registered VB low) and dma_req is high -> ARMED. If dma_req is not high at the VB rising edge, stay in IDLE until the next VB rise.
- ARMED: clear byte counter and overrun. Next clk -> REQ.
- REQ: busrq=1. When busak=1 -> ADDR.
- ADDR: src_addr = SRC_BASE + cnt. Transition -> WRITE requires all of: pxl_cen=1, HBD_n=0, busak=1.
- WRITE: on the next pxl_cen:
  - obj_addr = cnt[OAW-1:0]; obj_dout = src_din; obj_we = 1.
  - cnt increments.
  - If cnt was NBYTES-1 -> RELEASE, else -> ADDR.
- RELEASE: busrq=0, done=1 for one clk -> IDLE.
- Byte counter is OAW+1 bits wide. src_addr arithmetic is modulo 2^SAW; wrap past the top address is legal.
- busak drops while in ADDR or WRITE: freeze state and counter, keep busrq=1, resume when busak returns. No byte is lost or duplicated.
- HBD_n goes high while in ADDR: wait. A WRITE already entered completes on its pxl_cen regardless of HBD_n.
- VB falls in any state from ARMED through WRITE:
  - set overrun, go to RELEASE; done is not pulsed.
  - Bytes already written stay in object RAM.
- dma_req changes after arming: ignored until IDLE.
- VB rise while busy: ignored.

## Timing
- Reset values: busrq=0, obj_we=0, done=0, busy=0, overrun=0, src_addr=SRC_BASE, obj_addr=0, obj_dout=0, state IDLE. Reset mid-transfer drops busrq on the next clk.
- Minimum cost per byte: 2 pxl_cen (8 clk) inside an open window.
- Arm latency: VB rise -> busrq high = 2 clk (IDLE->ARMED->REQ).
- busak high -> ADDR: 1 clk. First obj_we: at the second qualifying pxl_cen after that.
- Last obj_we -> busrq low: 1 clk. done coincides with busrq falling.
- All outputs are registered.

## Test plan
- Basic transfer: dma_req=1, VB rises, busak=1 two clk after busrq, HBD_n held low, RAM model returns data=addr[7:0] -> 128 obj_we pulses, obj_addr 0..127 with data 00..7F, done pulse once, overrun=0.
- Window gating: HBD_n low only 16 pxl_cen of every 320 -> at most 8 bytes per window, no obj_we while HBD_n high except a completing WRITE, final contents identical to the basic case.
- Bus steal: busak deasserted for 50 clk after byte 40 -> no obj_we during the gap, bytes 41..127 follow with no gaps in address and no repeats.
- Overrun: VB falls after 60 bytes -> overrun=1, busrq=0 next clk, no done pulse. Re-arm on the next VB clears overrun and completes all 128 bytes.
- Not armed: dma_req=0 at VB rise, then raised mid-blank -> busrq stays 0 that frame; transfer runs on the following VB rise.
- Reset mid-transfer: rst at byte 20 -> next clk busrq=0, obj_we=0, busy=0; the next armed VB restarts at obj_addr 0.
